wb_dma_copy: RTL and testbench
==============================

Name: wb_dma_copy

Overview:
- Wishbone initiator that copies a block of 32-bit words from a source to a destination word address on the same bus.
- Each word is one read transaction followed by one write transaction; no pipelining across words.
- Sits beside the CPU on the SoC bus and drives RAM/peripheral Wishbone slaves.
- Also serves as the standard bench driver for exercising those slaves.

Parameters:
- ADDR_WIDTH, 16, word-address width of adr_o, src_i and dst_i.
- DATA_WIDTH, 32, bus data width; fixed at 32 because sel_o is 4 bits.
- LEN_WIDTH, 16, width of the transfer length in words.
- RDATA_DELAY, 1, cycles between ack_i and valid dat_i on reads; legal values 0 or 1.
- TIMEOUT, 255, maximum cycles to wait for ack_i per transaction before aborting.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle request to begin a copy; ignored while busy_o=1
- src_i  in  ADDR_WIDTH  source word address, sampled on accepted start
- dst_i  in  ADDR_WIDTH  destination word address, sampled on accepted start
- len_i  in  LEN_WIDTH  number of words to copy, sampled on accepted start
- busy_o  out  1  copy in progress
- done_o  out  1  one-cycle pulse on completion or abort
- err_o  out  1  sticky timeout flag; cleared by the next accepted start
- adr_o  out  ADDR_WIDTH  Wishbone address
- dat_o  out  DATA_WIDTH  Wishbone write data
- dat_i  in  DATA_WIDTH  Wishbone read data
- we_o  out  1  Wishbone write enable
- sel_o  out  4  byte select; always 4'hF while stb_o=1, otherwise 0
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- ack_i  in  1  Wishbone acknowledge
- stall_i  in  1  Wishbone stall

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; internal counters and data buffer 0.
- Reset takes effect immediately, including mid-transfer; cyc_o and stb_o drop asynchronously.

State machine:
- IDLE: on start_i, latch src/dst/len and clear err_o.
  - If len=0: go to DONE; no bus activity.
  - Otherwise: go to RD_REQ.
- RD_REQ: cyc_o=1, stb_o=1, we_o=0, adr_o=src.
  - Hold all signals while stall_i=1 or ack_i=0.
  - On ack_i: if RDATA_DELAY=0, capture dat_i and go to WR_REQ; else go to RD_WAIT.
- RD_WAIT: cyc_o=1, stb_o=0; capture dat_i; go to WR_REQ.
- WR_REQ: cyc_o=1, stb_o=1, we_o=1, adr_o=dst, dat_o=buffer.
  - On ack_i: src+1, dst+1, remaining-1.
  - If remaining was 1, go to DONE; otherwise go to RD_REQ.
- DONE: done_o=1, cyc_o=0, busy_o=0; go to IDLE.
- ERR: err_o=1, done_o=1, cyc_o=0, stb_o=0; go to IDLE.

Handshake and signal rules:
- ack_i is accepted in the same cycle as stb_o; it may arrive combinationally.
- ack_i is ignored when stb_o=0.
- cyc_o stays high for the whole copy, including RD_WAIT.
- busy_o=1 in RD_REQ, RD_WAIT and WR_REQ.

Timeout:
- A counter clears on entry to RD_REQ or WR_REQ and increments each cycle while stb_o=1 and ack_i=0.
- When it reaches TIMEOUT, go to ERR; the remaining words are not transferred.

Arithmetic and boundaries:
- Addresses wrap modulo 2^ADDR_WIDTH; e.g. src=16'hFFFF, len=2 reads FFFF then 0000.
- len_i = 2^LEN_WIDTH-1 is supported.
- start_i while busy is dropped and not queued.
- start_i in the DONE/ERR cycle is ignored.

Throughput:
- With zero-wait slaves and RDATA_DELAY=1, each word takes 3 cycles.
- done_o asserts 3N+1 cycles after the start edge.

Decomposition:
- Package wb_dma_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, ERR);
  - SEL_ALL = 4'hF;
  - the default TIMEOUT constant.
- One sub-module, wb_ack_timeout: counter with clear/enable inputs and an expired output, TIMEOUT parameter.

Test Plan:
- Zero-wait slave, RDATA_DELAY=1; RAM[0x10..0x13]=A0..A3; start src=0x10, dst=0x20, len=4 -> RAM[0x20..0x23]=A0..A3; done_o at cycle 13; err_o=0; sel_o=4'hF on every strobe.
- len=0 -> done_o the cycle after start; cyc_o never asserted.
- Slave stalls 5 cycles on each request -> stb_o, adr_o, dat_o held stable throughout; data copied correctly.
- src=0xFFFF, dst=0x0100, len=2 -> reads FFFF then 0000; writes 0100 then 0101.
- Slave never acks, TIMEOUT=8 -> ERR after 8 wait cycles; err_o=1, done_o pulse, cyc_o=0; next start clears err_o.
- rst_ni low during WR_REQ of word 2 of 4 -> all outputs 0 immediately; word 2 not written; a new start afterwards completes normally.

Source files
------------

// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone block-copy engine.
package wb_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [3:0]  SEL_ALL         = 4'hF;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_ack_timeout.sv
// Counts un-acked strobe cycles; flags expiry on the TIMEOUT-th waiting cycle.
module wb_ack_timeout
  import wb_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Wait-cycle counter, restarted for every new request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Expiry fires in the cycle that would be the TIMEOUT-th wait, so the
  // FSM leaves the request state exactly after TIMEOUT unacknowledged cycles.
  assign expired_c = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone initiator copying len words from src to dst, one read then one
// write per word, with a per-transaction ack timeout.
module wb_dma_copy
  import wb_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned RDATA_DELAY = 1,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic [ADDR_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  we_o,
  output logic [3:0]            sel_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  stall_i
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] buffer;
  logic                  accept_c;
  logic                  tmo_clear_c;
  logic                  tmo_en_c;
  logic                  tmo_expired_c;

  // A request completes only on an acknowledged, non-stalled strobe.
  assign accept_c    = stb_o && ack_i && !stall_i;
  assign tmo_en_c    = stb_o && !ack_i;
  assign tmo_clear_c = !stb_o || accept_c;

  wb_ack_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (tmo_clear_c),
    .enable    (tmo_en_c),
    .expired_c (tmo_expired_c)
  );

  // Copy sequencer; bus outputs are registered and set on state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      buffer    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      we_o      <= 1'b0;
      sel_o     <= '0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src       <= src_i;
            dst       <= dst_i;
            remaining <= len_i;
            err_o     <= 1'b0;
            if (len_i == '0) begin
              state <= DONE;
            end else begin
              state  <= RD_REQ;
              busy_o <= 1'b1;
              cyc_o  <= 1'b1;
              stb_o  <= 1'b1;
              we_o   <= 1'b0;
              sel_o  <= SEL_ALL;
              adr_o  <= src_i;
            end
          end
        end
        RD_REQ: begin
          if (tmo_expired_c) begin
            state  <= ERR;
            busy_o <= 1'b0;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            sel_o  <= '0;
          end else if (accept_c) begin
            if (RDATA_DELAY == 0) begin
              buffer <= dat_i;
              dat_o  <= dat_i;
              state  <= WR_REQ;
              we_o   <= 1'b1;
              adr_o  <= dst;
            end else begin
              state <= RD_WAIT;
              stb_o <= 1'b0;
              sel_o <= '0;
            end
          end
        end
        RD_WAIT: begin
          buffer <= dat_i;
          dat_o  <= dat_i;
          state  <= WR_REQ;
          stb_o  <= 1'b1;
          sel_o  <= SEL_ALL;
          we_o   <= 1'b1;
          adr_o  <= dst;
        end
        WR_REQ: begin
          if (tmo_expired_c) begin
            state  <= ERR;
            busy_o <= 1'b0;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            we_o   <= 1'b0;
            sel_o  <= '0;
          end else if (accept_c) begin
            src       <= src + ADDR_WIDTH'(1);
            dst       <= dst + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              cyc_o  <= 1'b0;
              stb_o  <= 1'b0;
              we_o   <= 1'b0;
              sel_o  <= '0;
            end else begin
              state <= RD_REQ;
              we_o  <= 1'b0;
              adr_o <= src + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        ERR: begin
          err_o  <= 1'b1;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy with a behavioural Wishbone RAM slave.
module tb_wb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src, dst, len;
  logic        busy, done, err, we, cyc, stb, ack, stall;
  logic [15:0] adr;
  logic [31:0] dat_w, dat_r;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;

  // Slave configuration and state
  logic [31:0] mem [0:65535];
  int          stall_cycles = 0;
  logic        no_ack = 1'b0;
  int          wait_cnt = 0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_adr = '0;
  logic [31:0] pl_dat = '0;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];

  wb_dma_copy #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (16),
    .RDATA_DELAY(1),
    .TIMEOUT    (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .src_i  (src),
    .dst_i  (dst),
    .len_i  (len),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err),
    .adr_o  (adr),
    .dat_o  (dat_w),
    .dat_i  (dat_r),
    .we_o   (we),
    .sel_o  (sel),
    .cyc_o  (cyc),
    .stb_o  (stb),
    .ack_i  (ack),
    .stall_i(stall)
  );

  always #5 clk = ~clk;

  assign stall = stb && (wait_cnt < stall_cycles);
  assign ack   = stb && !stall && !no_ack;

  // RAM slave: combinational ack, read data one cycle after ack.
  always @(posedge clk) begin
    if (stb && stall) wait_cnt <= wait_cnt + 1;
    else              wait_cnt <= 0;
    if (pl_en) mem[pl_adr] <= pl_dat;
    if (stb && ack && we) begin
      mem[adr] <= dat_w;
      wr_log.push_back(adr);
    end
    if (stb && ack && !we) begin
      dat_r <= mem[adr];
      rd_log.push_back(adr);
    end
  end

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_adr = a; pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Pulse start for one cycle; returns at the negedge after the start edge.
  task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles from the start edge until done is seen, collecting bus stats.
  task automatic wait_done(input int limit, output int cycles, output int sel_bad,
                           output int cyc_seen, output int stb_cnt, output int unstable);
    logic        p_stall = 1'b0;
    logic [15:0] p_adr = '0;
    logic [31:0] p_dat = '0;
    logic        p_we = 1'b0;
    cycles = 0; sel_bad = 0; cyc_seen = 0; stb_cnt = 0; unstable = 0;
    while (!done && cycles < limit) begin
      if (cyc) cyc_seen++;
      if (stb) stb_cnt++;
      if (stb && sel !== 4'hF) sel_bad++;
      if (!stb && sel !== 4'h0) sel_bad++;
      if (p_stall && (!stb || adr !== p_adr || dat_w !== p_dat || we !== p_we)) unstable++;
      p_stall = stb && stall;
      p_adr = adr; p_dat = dat_w; p_we = we;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (cyc !== 1'b0)   begin errors++; $display("FAIL reset_cyc got %b want 0", cyc); end
    checks++; if (stb !== 1'b0)   begin errors++; $display("FAIL reset_stb got %b want 0", stb); end
    checks++; if (we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b want 0", we); end
    checks++; if (sel !== 4'h0)   begin errors++; $display("FAIL reset_sel got %h want 0", sel); end
    checks++; if (adr !== 16'h0)  begin errors++; $display("FAIL reset_adr got %h want 0", adr); end
    checks++; if (dat_w !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", dat_w); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_copy();
    int cyc_n, sb, cs, sc, us;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), 32'h0000_00A0 + 32'(i));
    kick(16'h0010, 16'h0020, 16'd4);
    wait_done(100, cyc_n, sb, cs, sc, us);
    checks++; if (cyc_n != 13) begin errors++; $display("FAIL basic_done_cycle got %0d want 13", cyc_n); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
    checks++; if (sb != 0) begin errors++; $display("FAIL basic_sel got %0d bad cycles want 0", sb); end
    checks++; if (sc != 8) begin errors++; $display("FAIL basic_strobes got %0d want 8", sc); end
    for (int i = 0; i < 4; i++) begin
      d = mem[16'h0020 + 16'(i)];
      checks++;
      if (d !== 32'h0000_00A0 + 32'(i)) begin
        errors++; $display("FAIL basic_data[%0d] got %h want %h", i, d, 32'h0000_00A0 + 32'(i));
      end
    end
  endtask

  task automatic test_len_zero();
    int cyc_n, sb, cs, sc, us;
    kick(16'h0010, 16'h0030, 16'd0);
    wait_done(20, cyc_n, sb, cs, sc, us);
    checks++; if (cyc_n != 1) begin errors++; $display("FAIL len0_done_cycle got %0d want 1", cyc_n); end
    checks++; if (cs != 0) begin errors++; $display("FAIL len0_cyc got %0d active cycles want 0", cs); end
  endtask

  task automatic test_stall();
    int cyc_n, sb, cs, sc, us;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) poke(16'h0040 + 16'(i), 32'h5A5A_0000 + 32'(i * 17));
    stall_cycles = 5;
    kick(16'h0040, 16'h0050, 16'd3);
    // per word: 6 read cycles + 1 wait + 6 write cycles
    wait_done(200, cyc_n, sb, cs, sc, us);
    stall_cycles = 0;
    checks++; if (cyc_n != 40) begin errors++; $display("FAIL stall_done_cycle got %0d want 40", cyc_n); end
    checks++; if (us != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", us); end
    checks++; if (sb != 0) begin errors++; $display("FAIL stall_sel got %0d want 0", sb); end
    for (int i = 0; i < 3; i++) begin
      d = mem[16'h0050 + 16'(i)];
      checks++;
      if (d !== 32'h5A5A_0000 + 32'(i * 17)) begin
        errors++; $display("FAIL stall_data[%0d] got %h want %h", i, d, 32'h5A5A_0000 + 32'(i * 17));
      end
    end
  endtask

  task automatic test_wrap();
    int cyc_n, sb, cs, sc, us;
    logic [31:0] d0, d1;
    poke(16'hFFFF, 32'hDEAD_BEEF);
    poke(16'h0000, 32'h1234_5678);
    rd_log.delete(); wr_log.delete();
    kick(16'hFFFF, 16'h0100, 16'd2);
    wait_done(50, cyc_n, sb, cs, sc, us);
    checks++; if (cyc_n != 7) begin errors++; $display("FAIL wrap_done_cycle got %0d want 7", cyc_n); end
    checks++;
    if (rd_log.size() != 2) begin
      errors++; $display("FAIL wrap_reads got %0d want 2", rd_log.size());
    end else if (rd_log[0] !== 16'hFFFF || rd_log[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_read_adr got %h,%h want ffff,0000", rd_log[0], rd_log[1]);
    end
    checks++;
    if (wr_log.size() != 2) begin
      errors++; $display("FAIL wrap_writes got %0d want 2", wr_log.size());
    end else if (wr_log[0] !== 16'h0100 || wr_log[1] !== 16'h0101) begin
      errors++; $display("FAIL wrap_write_adr got %h,%h want 0100,0101", wr_log[0], wr_log[1]);
    end
    d0 = mem[16'h0100]; d1 = mem[16'h0101];
    checks++; if (d0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wrap_data0 got %h want deadbeef", d0); end
    checks++; if (d1 !== 32'h1234_5678) begin errors++; $display("FAIL wrap_data1 got %h want 12345678", d1); end
  endtask

  task automatic test_timeout();
    int cyc_n, sb, cs, sc, us;
    no_ack = 1'b1;
    kick(16'h0060, 16'h0068, 16'd3);
    wait_done(100, cyc_n, sb, cs, sc, us);
    no_ack = 1'b0;
    checks++; if (sc != 8) begin errors++; $display("FAIL tmo_wait_cycles got %0d want 8", sc); end
    checks++; if (cyc_n != 9) begin errors++; $display("FAIL tmo_done_cycle got %0d want 9", cyc_n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", err); end
    checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL tmo_cyc got %b want 0", cyc); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL tmo_done_pulse got %b want 0", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b want 1", err); end
    poke(16'h0061, 32'hCAFE_0001);
    kick(16'h0061, 16'h0069, 16'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear got %b want 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_restart_busy got %b want 1", busy); end
    wait_done(50, cyc_n, sb, cs, sc, us);
    checks++; if (cyc_n != 4) begin errors++; $display("FAIL tmo_restart_cycle got %0d want 4", cyc_n); end
    checks++; if (mem[16'h0069] !== 32'hCAFE_0001) begin
      errors++; $display("FAIL tmo_restart_data got %h want cafe0001", mem[16'h0069]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc_n, sb, cs, sc, us;
    int n;
    for (int i = 0; i < 4; i++) poke(16'h0070 + 16'(i), 32'hB000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) poke(16'h0080 + 16'(i), 32'h0);
    kick(16'h0070, 16'h0080, 16'd4);
    n = 0;
    while (!(stb && we && adr == 16'h0081) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL midrst_reach_wr2 got timeout want write of word 2");
    end
    rst_n = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL midrst_cyc got %b want 0", cyc); end
    checks++; if (stb !== 1'b0) begin errors++; $display("FAIL midrst_stb got %b want 0", stb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (adr !== 16'h0 || we !== 1'b0 || sel !== 4'h0 || dat_w !== 32'h0) begin
      errors++; $display("FAIL midrst_bus got adr=%h we=%b sel=%h dat=%h want all 0", adr, we, sel, dat_w);
    end
    @(posedge clk);
    #1;
    checks++; if (mem[16'h0080] !== 32'hB000_0000) begin
      errors++; $display("FAIL midrst_word1 got %h want b0000000", mem[16'h0080]);
    end
    checks++; if (mem[16'h0081] !== 32'h0) begin
      errors++; $display("FAIL midrst_word2 got %h want 0", mem[16'h0081]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    kick(16'h0072, 16'h0090, 16'd2);
    wait_done(50, cyc_n, sb, cs, sc, us);
    checks++; if (cyc_n != 7) begin errors++; $display("FAIL midrst_restart_cycle got %0d want 7", cyc_n); end
    checks++; if (mem[16'h0090] !== 32'hB000_0002 || mem[16'h0091] !== 32'hB000_0003) begin
      errors++; $display("FAIL midrst_restart_data got %h,%h want b0000002,b0000003", mem[16'h0090], mem[16'h0091]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_len_zero();
    test_stall();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
